// File: rtl/pipelined_n_bit_adder_pkg.sv
// rtl/pipelined_n_bit_adder_pkg.sv - shared op encoding and stage-count helper for the pipelined adder
package n_bit_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of registered ripple slices; each slice is also one cycle of latency.
    function automatic int stages_of(input int n, input int chunk);
        return n / chunk;
    endfunction

endpackage

// File: rtl/pipelined_n_bit_adder_if.sv
// rtl/pipelined_n_bit_adder_if.sv - operand/result handshake bundle for the pipelined adder
interface pipelined_n_bit_adder_if
    import n_bit_adder_pkg::*;
#(
    parameter int N = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    op_e          in_op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, in_a, in_b, in_cin, in_op, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf
    );

    // The adder itself.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf
    );
endinterface

// File: rtl/pipelined_n_bit_adder_chunk.sv
// rtl/pipelined_n_bit_adder_chunk.sv - full adder cell and CHUNK-bit ripple slice
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    // Each bit owns its carry nets so the ripple chain is a plain feed-forward path.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_lsb
            assign ci = cin;
        end else begin : g_chain
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (ci),
            .s  (sum[i]),
            .co (co)
        );
    end

    assign cout = g_bit[CHUNK-1].co;
    // Carry into the top bit; XOR with cout gives signed overflow for the final slice.
    assign cmsb = g_bit[CHUNK-1].ci;
endmodule

// File: rtl/pipelined_n_bit_adder.sv
// rtl/pipelined_n_bit_adder.sv - N-bit add/subtract split into registered CHUNK-bit ripple stages
module pipelined_n_bit_adder
    import n_bit_adder_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_n_bit_adder_if.slave bus
);
    localparam int STAGES = stages_of(N, CHUNK);

    if ((N % CHUNK) != 0 || STAGES < 1) begin : g_bad_width
        $error("pipelined_n_bit_adder: N must be a positive multiple of CHUNK");
    end

    // One global enable: a result waiting on the consumer freezes the whole pipe.
    logic stall;
    logic en;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign en           = !stall;
    assign bus.in_ready = en;

    // Stage k consumes the low CHUNK bits of the operands it is handed, forwards the
    // unconsumed upper bits and appends its slice to the accumulated sum.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = N - k * CHUNK;
        localparam int DONE = (k + 1) * CHUNK;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK-1:0] s_chunk;
        logic             c_out;
        logic             c_msb;
        logic [DONE-1:0]  s_next;
        logic             v_q;
        logic             c_q;
        logic [DONE-1:0]  s_q;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + !cin, so B and the carry are inverted on entry.
            assign a_in   = bus.in_a;
            assign b_in   = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
            assign c_in   = (bus.in_op == OP_SUB) ? ~bus.in_cin : bus.in_cin;
            assign v_in   = bus.in_valid;
            assign s_next = s_chunk;
        end else begin : g_body
            assign a_in   = g_stage[k-1].g_fwd.a_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            assign s_next = {s_chunk, g_stage[k-1].s_q};
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_in[CHUNK-1:0]),
            .b    (b_in[CHUNK-1:0]),
            .cin  (c_in),
            .sum  (s_chunk),
            .cout (c_out),
            .cmsb (c_msb)
        );

        // Valid advances every enabled cycle; data is captured only for real beats so
        // bubble contents never leak into the stage registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= c_out;
                    s_q <= s_next;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;
            logic                 unused_msb;
            assign unused_msb = c_msb;

            // Skew the not-yet-added operand bits forward to the next slice.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && v_in) begin
                    a_q <= a_in[REM-1:CHUNK];
                    b_q <= b_in[REM-1:CHUNK];
                end
            end
        end else begin : g_tail
            logic o_q;

            // Signed overflow is decided by the carries around the top bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_q <= 1'b0;
                end else if (en && v_in) begin
                    o_q <= c_out ^ c_msb;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.out_sum   = g_stage[STAGES-1].s_q;
    assign bus.out_carry = g_stage[STAGES-1].c_q;
    assign bus.out_ovf   = g_stage[STAGES-1].g_tail.o_q;
endmodule

// File: tb/tb_pipelined_n_bit_adder.sv
// tb/tb_pipelined_n_bit_adder.sv - self-checking bench for the pipelined adder
module tb_pipelined_n_bit_adder;
    import n_bit_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_n_bit_adder_if #(.N(8)) ia ();
    pipelined_n_bit_adder_if #(.N(4)) ib ();

    pipelined_n_bit_adder #(.N(8), .CHUNK(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    pipelined_n_bit_adder #(.N(4), .CHUNK(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, returns {ovf, carry, sum[7:0]}.
    function automatic logic [9:0] model(input int n, input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input op_e op);
        longint mask, half, ua, ub, sa, sb, full, sres;
        logic carry, ovf;
        logic [7:0] sum;
        mask = (longint'(1) << n) - 1;
        half = longint'(1) << (n - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= half) ? ua - (longint'(1) << n) : ua;
        sb = (ub >= half) ? ub - (longint'(1) << n) : ub;
        if (op == OP_ADD) begin
            full  = ua + ub + longint'(cin);
            sres  = sa + sb + longint'(cin);
            carry = ((full >> n) & 1) != 0;
        end else begin
            full  = ua - ub - longint'(cin);
            sres  = sa - sb - longint'(cin);
            carry = (full >= 0);
        end
        sum = 8'(full & mask);
        ovf = (sres > half - 1) || (sres < -half);
        return {ovf, carry, sum};
    endfunction

    // Scoreboard: every accepted beat queues its expected result; every cycle with a
    // valid result is compared against the oldest outstanding expectation.
    logic [9:0] exp_q[$];
    int         n_out = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out = '0;

    always @(negedge clk) begin
        logic [9:0] cur;
        cur = {ia.out_ovf, ia.out_carry, ia.out_sum};
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", ia.in_ready, !(ia.out_valid && !ia.out_ready));
            if (prev_stall) begin
                check("hold_valid", ia.out_valid, 1'b1);
                check("hold_data", cur, prev_out);
            end
            if (ia.out_valid) begin
                if (exp_q.size() == 0) check("spurious_out", 1'b1, 1'b0);
                else check("result", cur, exp_q[0]);
                if (ia.out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    n_out++;
                end
            end
            prev_stall = ia.out_valid && !ia.out_ready;
            prev_out   = cur;
            if (ia.in_valid && ia.in_ready)
                exp_q.push_back(model(8, ia.in_a, ia.in_b, ia.in_cin, ia.in_op));
        end
    end

    task automatic junk_inputs();
        ia.in_a   = 8'($urandom);
        ia.in_b   = 8'($urandom);
        ia.in_cin = 1'($urandom);
        ia.in_op  = op_e'($urandom_range(0, 1));
    endtask

    // Present one beat starting at posedge+1, return at posedge+1 after its handshake.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic cin, input op_e op);
        int guard;
        ia.in_valid = 1'b1;
        ia.in_a     = a;
        ia.in_b     = b;
        ia.in_cin   = cin;
        ia.in_op    = op;
        guard = 0;
        forever begin
            @(negedge clk);
            if (ia.in_ready) break;
            guard++;
            if (guard > 200) begin
                check("beat_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
        junk_inputs();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        op_e        op;
        logic [9:0] exp;
    } vec_t;

    vec_t dir_vecs[4] = '{
        '{8'hFF, 8'h01, 1'b0, OP_ADD, {1'b0, 1'b1, 8'h00}},
        '{8'h7F, 8'h01, 1'b0, OP_ADD, {1'b1, 1'b0, 8'h80}},
        '{8'h05, 8'h07, 1'b0, OP_SUB, {1'b0, 1'b0, 8'hFE}},
        '{8'h80, 8'h01, 1'b0, OP_SUB, {1'b1, 1'b1, 8'h7F}}
    };

    initial begin
        #900000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   sent;
        logic acc;

        rst_n        = 1'b0;
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        junk_inputs();
        ib.in_valid  = 1'b0;
        ib.out_ready = 1'b1;
        ib.in_a      = '0;
        ib.in_b      = '0;
        ib.in_cin    = 1'b0;
        ib.in_op     = OP_ADD;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", ia.out_valid, 1'b0);
        check("rst_out_sum", ia.out_sum, 8'h00);
        check("rst_out_carry", ia.out_carry, 1'b0);
        check("rst_out_ovf", ia.out_ovf, 1'b0);
        check("rst_in_ready", ia.in_ready, 1'b1);
        check("rst_b_out_valid", ib.out_valid, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner values, latency exactly two cycles with an idle pipe.
        foreach (dir_vecs[i]) begin
            check("model_pin", model(8, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].cin, dir_vecs[i].op),
                  dir_vecs[i].exp);
            beat(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].cin, dir_vecs[i].op);
            check("lat_not_1", ia.out_valid, 1'b0);
            @(posedge clk);
            #1;
            check("lat_2_valid", ia.out_valid, 1'b1);
            check("dir_result", {ia.out_ovf, ia.out_carry, ia.out_sum}, dir_vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Six back-to-back beats with the consumer stalling for three cycles.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    beat(8'($urandom), 8'($urandom), 1'($urandom), op_e'($urandom_range(0, 1)));
            end
            begin
                repeat (3) @(posedge clk);
                #1 ia.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 ia.out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 50 && n_out != base + 6; i++) @(posedge clk);
        #1;
        check("stall_count", n_out - base, 6);
        check("stall_drained", exp_q.size(), 0);

        // Reset with two beats in flight discards them.
        beat(8'h11, 8'h22, 1'b0, OP_ADD);
        beat(8'h33, 8'h44, 1'b0, OP_SUB);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", ia.out_valid, 1'b0);
        check("midrst_in_ready", ia.in_ready, 1'b1);
        check("midrst_out_sum", ia.out_sum, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        base = n_out;
        repeat (4) @(posedge clk);
        #1;
        check("no_ghost_beats", n_out - base, 0);
        check("post_rst_idle", ia.out_valid, 1'b0);
        check("model_pin_rst", model(8, 8'h12, 8'h34, 1'b1, OP_ADD), {1'b0, 1'b0, 8'h47});
        beat(8'h12, 8'h34, 1'b1, OP_ADD);
        check("post_rst_lat_not_1", ia.out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst_lat_2", ia.out_valid, 1'b1);
        check("post_rst_result", {ia.out_ovf, ia.out_carry, ia.out_sum}, {1'b0, 1'b0, 8'h47});

        // Single-stage configuration: registered full-width ripple, latency one.
        check("model_pin_n4", model(4, 8'h09, 8'h08, 1'b1, OP_ADD), {1'b1, 1'b1, 8'h02});
        ib.in_valid = 1'b1;
        ib.in_a     = 4'h9;
        ib.in_b     = 4'h8;
        ib.in_cin   = 1'b1;
        ib.in_op    = OP_ADD;
        #1;
        check("n4_in_ready", ib.in_ready, 1'b1);
        @(posedge clk);
        #1;
        ib.in_valid = 1'b0;
        check("n4_lat_1", ib.out_valid, 1'b1);
        check("n4_result", {ib.out_ovf, ib.out_carry, ib.out_sum}, {1'b1, 1'b1, 4'h2});
        @(posedge clk);
        #1;
        check("n4_drained", ib.out_valid, 1'b0);

        // Random stream with random backpressure; the scoreboard checks every result.
        sent = 0;
        for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            @(negedge clk);
            acc = ia.in_valid && ia.in_ready;
            if (acc) sent++;
            @(posedge clk);
            #1;
            if (!ia.in_valid || acc) begin
                ia.in_valid = ($urandom_range(0, 3) != 0) && (sent < 10000);
                junk_inputs();
            end
            ia.out_ready = ($urandom_range(0, 3) != 0);
        end
        check("random_sent", sent, 10000);
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("random_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
